// File: rtl/sram_oq_pkg.sv
// Shared constants, op encoding and sizing helpers for the SRAM output-queue scheduler.
package sram_oq_pkg;

    localparam int DEF_DATA_WIDTH     = 202;
    localparam int DEF_NUM_QUEUES     = 5;
    localparam int DEF_MEM_ADDR_WIDTH = 19;
    localparam int DEF_QUEUE_SIZE     = 104857;
    localparam int DEF_MEM_RD_LATENCY = 2;

    typedef enum logic {
        OP_WR = 1'b0,
        OP_RD = 1'b1
    } op_e;

    // First word address of partition q.
    function automatic int queue_base(input int q, input int qsize);
        return q * qsize;
    endfunction

    // Last word address of partition q; a pointer here wraps back to queue_base.
    function automatic int queue_last(input int q, input int qsize);
        return q * qsize + qsize - 1;
    endfunction

    // Occupancy counters must be able to hold the full value qsize.
    function automatic int cnt_width(input int qsize);
        return $clog2(qsize + 1);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 5,
    parameter int IW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin : arb_scan
        int cand;
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/sram_oq_mem_scheduler.sv
// Arbitrates the single SRAM port between the packed write stream and per-queue egress reads,
// keeping circular head/tail/count state for each fixed SRAM partition.
module sram_oq_mem_scheduler
    import sram_oq_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int NUM_QUEUES     = DEF_NUM_QUEUES,
    parameter int MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH,
    parameter int QUEUE_SIZE     = DEF_QUEUE_SIZE,
    parameter int MEM_RD_LATENCY = DEF_MEM_RD_LATENCY
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [NUM_QUEUES-1:0]     wr_oq,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [NUM_QUEUES-1:0]     rd_req,
    output logic                      rd_valid,
    output logic [NUM_QUEUES-1:0]     rd_oq,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic [NUM_QUEUES-1:0]     queue_empty,
    output logic [NUM_QUEUES-1:0]     queue_full,
    output logic                      wr_drop
);

    localparam int AW = MEM_ADDR_WIDTH;
    localparam int CW = cnt_width(QUEUE_SIZE);
    localparam int QW = idx_width(NUM_QUEUES);

    op_e                                  last_op_reg;
    logic [QW-1:0]                        rr_ptr_reg;
    logic [NUM_QUEUES-1:0]                rd_tag_reg;
    logic [MEM_RD_LATENCY-1:0][NUM_QUEUES-1:0] tag_pipe_reg;

    logic [NUM_QUEUES-1:0][AW-1:0] head_vec;
    logic [NUM_QUEUES-1:0][AW-1:0] tail_vec;

    logic [NUM_QUEUES-1:0] wr_tgt_oh;
    logic [QW-1:0]         wr_idx;
    logic                  wr_any_oq;
    logic                  wr_cand;
    logic                  wr_fire;
    logic                  wr_issue;
    logic [NUM_QUEUES-1:0] rd_req_eff;
    logic [NUM_QUEUES-1:0] rd_gnt_oh;
    logic [QW-1:0]         rd_idx;
    logic                  rd_cand;
    logic                  rd_fire;

    // Lowest set bit of wr_oq selects the target if more than one bit is set.
    assign wr_any_oq = |wr_oq;
    assign wr_tgt_oh = wr_oq & (~wr_oq + NUM_QUEUES'(1));

    always_comb begin
        wr_idx = '0;
        for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
            if (wr_oq[i]) begin
                wr_idx = QW'(i);
            end
        end
    end

    assign wr_cand    = wr_valid & (~wr_any_oq | ~|(wr_tgt_oh & queue_full));
    assign rd_req_eff = rd_req & ~queue_empty;

    rr_arbiter #(
        .N  (NUM_QUEUES),
        .IW (QW)
    ) u_rr_arbiter (
        .req (rd_req_eff),
        .ptr (rr_ptr_reg),
        .gnt (rd_gnt_oh),
        .idx (rd_idx),
        .any (rd_cand)
    );

    // When both sides compete, the side that did not win last time goes first.
    assign wr_fire  = wr_cand & (~rd_cand | (last_op_reg == OP_RD));
    assign rd_fire  = rd_cand & (~wr_cand | (last_op_reg == OP_WR));
    assign wr_issue = wr_fire & wr_any_oq;
    assign wr_ready = wr_fire;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_QUEUES; gi++) begin : gen_queue
            localparam logic [AW-1:0] BASE     = AW'(queue_base(gi, QUEUE_SIZE));
            localparam logic [AW-1:0] LAST     = AW'(queue_last(gi, QUEUE_SIZE));
            localparam logic [CW-1:0] CNT_FULL = CW'(QUEUE_SIZE);

            logic [AW-1:0] head_reg;
            logic [AW-1:0] tail_reg;
            logic [CW-1:0] count_reg;
            logic          empty_reg;
            logic          full_reg;
            logic          push;
            logic          pop;

            assign push = wr_issue & wr_tgt_oh[gi];
            assign pop  = rd_fire & rd_gnt_oh[gi];

            // Flags are recomputed from the same update as the count, so they never lag it.
            always_ff @(posedge clk) begin
                if (reset) begin
                    head_reg  <= BASE;
                    tail_reg  <= BASE;
                    count_reg <= '0;
                    empty_reg <= 1'b1;
                    full_reg  <= 1'b0;
                end else if (push) begin
                    tail_reg  <= (tail_reg == LAST) ? BASE : tail_reg + AW'(1);
                    count_reg <= count_reg + CW'(1);
                    empty_reg <= 1'b0;
                    full_reg  <= (count_reg == CNT_FULL - CW'(1));
                end else if (pop) begin
                    head_reg  <= (head_reg == LAST) ? BASE : head_reg + AW'(1);
                    count_reg <= count_reg - CW'(1);
                    empty_reg <= (count_reg == CW'(1));
                    full_reg  <= 1'b0;
                end
            end

            assign head_vec[gi]    = head_reg;
            assign tail_vec[gi]    = tail_reg;
            assign queue_empty[gi] = empty_reg;
            assign queue_full[gi]  = full_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            last_op_reg <= OP_RD;
            rr_ptr_reg  <= '0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rd_tag_reg  <= '0;
            wr_drop     <= 1'b0;
        end else begin
            mem_en     <= wr_issue | rd_fire;
            mem_we     <= wr_issue;
            rd_tag_reg <= rd_fire ? rd_gnt_oh : '0;
            wr_drop    <= wr_fire & ~wr_any_oq;
            if (wr_issue) begin
                mem_addr  <= tail_vec[wr_idx];
                mem_wdata <= wr_data;
            end else if (rd_fire) begin
                mem_addr <= head_vec[rd_idx];
            end
            if (wr_fire) begin
                last_op_reg <= OP_WR;
            end else if (rd_fire) begin
                last_op_reg <= OP_RD;
            end
            if (rd_fire) begin
                rr_ptr_reg <= (rd_idx == QW'(NUM_QUEUES - 1)) ? '0 : rd_idx + QW'(1);
            end
        end
    end

    // Read tags ride alongside the SRAM read pipeline; reset flushes reads already in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_pipe_reg <= '0;
        end else begin
            tag_pipe_reg[0] <= rd_tag_reg;
            for (int i = 1; i < MEM_RD_LATENCY; i++) begin
                tag_pipe_reg[i] <= tag_pipe_reg[i-1];
            end
        end
    end

    assign rd_oq    = tag_pipe_reg[MEM_RD_LATENCY-1];
    assign rd_valid = |tag_pipe_reg[MEM_RD_LATENCY-1];
    assign rd_data  = mem_rdata;

endmodule

// File: tb/tb_sram_oq_mem_scheduler.sv
// Directed bench: 4-word partitions, 2-cycle SRAM model, hand-computed expectations.
module tb_sram_oq_mem_scheduler;

    localparam int DW  = 202;
    localparam int NQ  = 5;
    localparam int AW  = 19;
    localparam int QS  = 4;
    localparam int LAT = 2;

    typedef logic [255:0] w_t;

    logic          clk;
    logic          reset;
    logic          wr_valid;
    logic          wr_ready;
    logic [NQ-1:0] wr_oq;
    logic [DW-1:0] wr_data;
    logic [NQ-1:0] rd_req;
    logic          rd_valid;
    logic [NQ-1:0] rd_oq;
    logic [DW-1:0] rd_data;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [NQ-1:0] queue_empty;
    logic [NQ-1:0] queue_full;
    logic          wr_drop;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] mem_model [0:31];
    logic [DW-1:0] rd_pipe1;
    logic [DW-1:0] rd_pipe2;

    int t2_addr [6] = '{0, 1, 2, 0, 0, 0};
    int t2_rv   [6] = '{0, 0, 1, 1, 1, 0};
    int t3_rdy  [4] = '{0, 1, 0, 1};
    int t3_addr [4] = '{4, 8, 5, 9};
    int t4_oq   [4] = '{1, 1, 4, 16};
    int t4_waddr[4] = '{0, 1, 8, 16};
    int t4_raddr[4] = '{0, 8, 16, 1};
    int t4_roq  [6] = '{0, 0, 1, 4, 16, 1};
    int t4_rdat [6] = '{0, 0, 'hE0, 'hE2, 'hE3, 'hE1};

    sram_oq_mem_scheduler #(
        .DATA_WIDTH     (DW),
        .NUM_QUEUES     (NQ),
        .MEM_ADDR_WIDTH (AW),
        .QUEUE_SIZE     (QS),
        .MEM_RD_LATENCY (LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_oq       (wr_oq),
        .wr_data     (wr_data),
        .rd_req      (rd_req),
        .rd_valid    (rd_valid),
        .rd_oq       (rd_oq),
        .rd_data     (rd_data),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .queue_empty (queue_empty),
        .queue_full  (queue_full),
        .wr_drop     (wr_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: data for a read strobe appears two cycles after the strobe cycle.
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem_model[mem_addr[4:0]] <= mem_wdata;
        end
        rd_pipe1 <= (mem_en && !mem_we) ? mem_model[mem_addr[4:0]] : '0;
        rd_pipe2 <= rd_pipe1;
    end
    assign mem_rdata = rd_pipe2;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input w_t obs, input w_t exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset    = 1'b1;
        wr_valid = 1'b0;
        wr_oq    = '0;
        wr_data  = '0;
        rd_req   = '0;
        repeat (3) step();
        reset = 1'b0;

        // reset state
        chk("rst_empty", w_t'(queue_empty), w_t'(5'h1f));
        chk("rst_full", w_t'(queue_full), w_t'(0));
        chk("rst_mem_en", w_t'(mem_en), w_t'(0));
        chk("rst_rd_valid", w_t'(rd_valid), w_t'(0));
        chk("rst_wr_drop", w_t'(wr_drop), w_t'(0));
        chk("rst_wr_ready", w_t'(wr_ready), w_t'(0));

        // three writes to q0
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_oq    = 5'b00001;
            wr_data  = DW'('hA0 + i);
            #1 chk("t1_wr_ready", w_t'(wr_ready), w_t'(1));
            step();
            chk("t1_mem_en", w_t'(mem_en), w_t'(1));
            chk("t1_mem_we", w_t'(mem_we), w_t'(1));
            chk("t1_mem_addr", w_t'(mem_addr), w_t'(i));
            chk("t1_mem_wdata", w_t'(mem_wdata), w_t'('hA0 + i));
            chk("t1_rd_valid", w_t'(rd_valid), w_t'(0));
        end
        wr_valid = 1'b0;
        wr_oq    = '0;
        chk("t1_empty", w_t'(queue_empty), w_t'(5'h1e));

        // drain q0: reads at 0,1,2, data back three cycles after each grant
        rd_req = 5'b00001;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t2_mem_en", w_t'(mem_en), w_t'(i < 3));
            if (i < 3) begin
                chk("t2_mem_we", w_t'(mem_we), w_t'(0));
                chk("t2_mem_addr", w_t'(mem_addr), w_t'(t2_addr[i]));
            end
            chk("t2_rd_valid", w_t'(rd_valid), w_t'(t2_rv[i]));
            if (t2_rv[i] != 0) begin
                chk("t2_rd_oq", w_t'(rd_oq), w_t'(5'b00001));
                chk("t2_rd_data", w_t'(rd_data), w_t'('hA0 + i - 2));
            end
        end
        chk("t2_empty", w_t'(queue_empty), w_t'(5'h1f));
        rd_req = '0;

        // preload q1 with two words, then contend: write q2 vs read q1
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1;
            wr_oq    = 5'b00010;
            wr_data  = DW'('hF0 + i);
            step();
            chk("t3_pre_addr", w_t'(mem_addr), w_t'(4 + i));
        end
        wr_oq  = 5'b00100;
        rd_req = 5'b00010;
        for (int i = 0; i < 4; i++) begin
            wr_data = DW'('hC0 + i);
            #1 chk("t3_wr_ready", w_t'(wr_ready), w_t'(t3_rdy[i]));
            step();
            chk("t3_mem_en", w_t'(mem_en), w_t'(1));
            chk("t3_mem_we", w_t'(mem_we), w_t'(t3_rdy[i]));
            chk("t3_mem_addr", w_t'(mem_addr), w_t'(t3_addr[i]));
            if (t3_rdy[i] != 0) begin
                chk("t3_mem_wdata", w_t'(mem_wdata), w_t'('hC0 + i));
            end
            chk("t3_rd_valid", w_t'(rd_valid), w_t'(i == 2));
            if (i == 2) begin
                chk("t3_rd_oq", w_t'(rd_oq), w_t'(5'b00010));
                chk("t3_rd_data", w_t'(rd_data), w_t'('hF0));
            end
        end
        wr_valid = 1'b0;
        wr_oq    = '0;
        rd_req   = '0;
        step();
        chk("t3_idle_en", w_t'(mem_en), w_t'(0));
        chk("t3_rd_valid2", w_t'(rd_valid), w_t'(1));
        chk("t3_rd_oq2", w_t'(rd_oq), w_t'(5'b00010));
        chk("t3_rd_data2", w_t'(rd_data), w_t'('hF1));
        step();
        chk("t3_rd_valid3", w_t'(rd_valid), w_t'(0));

        // fresh reset, fill q0 x2, q2, q4, then round-robin reads
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_oq    = NQ'(t4_oq[i]);
            wr_data  = DW'('hE0 + i);
            step();
            chk("t4_wr_addr", w_t'(mem_addr), w_t'(t4_waddr[i]));
        end
        wr_valid = 1'b0;
        wr_oq    = '0;
        rd_req   = 5'b10101;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t4_mem_en", w_t'(mem_en), w_t'(i < 4));
            if (i < 4) begin
                chk("t4_rd_addr", w_t'(mem_addr), w_t'(t4_raddr[i]));
            end
            chk("t4_rd_valid", w_t'(rd_valid), w_t'(t4_roq[i] != 0));
            if (t4_roq[i] != 0) begin
                chk("t4_rd_oq", w_t'(rd_oq), w_t'(t4_roq[i]));
                chk("t4_rd_data", w_t'(rd_data), w_t'(t4_rdat[i]));
            end
        end
        rd_req = '0;
        step();
        chk("t4_rd_valid_end", w_t'(rd_valid), w_t'(0));
        chk("t4_empty", w_t'(queue_empty), w_t'(5'h1f));

        // fill q1 to full, stall, free one slot, write wraps to address 4
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_oq    = 5'b00010;
            wr_data  = DW'('h90 + i);
            step();
            chk("t5_wr_addr", w_t'(mem_addr), w_t'(4 + i));
        end
        chk("t5_full", w_t'(queue_full), w_t'(5'b00010));
        wr_data = DW'('h94);
        #1 chk("t5_stall_ready", w_t'(wr_ready), w_t'(0));
        step();
        chk("t5_stall_en", w_t'(mem_en), w_t'(0));
        rd_req = 5'b00010;
        #1 chk("t5_rd_ready", w_t'(wr_ready), w_t'(0));
        step();
        rd_req = '0;
        chk("t5_rd_en", w_t'(mem_en), w_t'(1));
        chk("t5_rd_we", w_t'(mem_we), w_t'(0));
        chk("t5_rd_addr", w_t'(mem_addr), w_t'(4));
        chk("t5_not_full", w_t'(queue_full), w_t'(0));
        #1 chk("t5_resume_ready", w_t'(wr_ready), w_t'(1));
        step();
        chk("t5_wrap_we", w_t'(mem_we), w_t'(1));
        chk("t5_wrap_addr", w_t'(mem_addr), w_t'(4));
        chk("t5_wrap_wdata", w_t'(mem_wdata), w_t'('h94));
        chk("t5_full_again", w_t'(queue_full), w_t'(5'b00010));
        wr_valid = 1'b0;
        wr_oq    = '0;
        step();
        chk("t5_rd_valid", w_t'(rd_valid), w_t'(1));
        chk("t5_rd_oq", w_t'(rd_oq), w_t'(5'b00010));
        chk("t5_rd_data", w_t'(rd_data), w_t'('h90));

        // write with no queue selected is dropped
        wr_valid = 1'b1;
        wr_oq    = '0;
        wr_data  = DW'('h55);
        #1 chk("t6_drop_ready", w_t'(wr_ready), w_t'(1));
        step();
        chk("t6_wr_drop", w_t'(wr_drop), w_t'(1));
        chk("t6_drop_en", w_t'(mem_en), w_t'(0));
        chk("t6_drop_full", w_t'(queue_full), w_t'(5'b00010));
        wr_valid = 1'b0;
        step();
        chk("t6_wr_drop_end", w_t'(wr_drop), w_t'(0));

        // reset while reads are in flight
        rd_req = 5'b00010;
        step();
        chk("t6_rd_addr", w_t'(mem_addr), w_t'(5));
        step();
        reset = 1'b1;
        step();
        chk("t6_rst_rd_valid", w_t'(rd_valid), w_t'(0));
        chk("t6_rst_empty", w_t'(queue_empty), w_t'(5'h1f));
        chk("t6_rst_full", w_t'(queue_full), w_t'(0));
        chk("t6_rst_mem_en", w_t'(mem_en), w_t'(0));
        reset  = 1'b0;
        rd_req = '0;
        step();
        chk("t6_post_rd_valid", w_t'(rd_valid), w_t'(0));
        step();
        chk("t6_post_rd_valid2", w_t'(rd_valid), w_t'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
